// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_unit_pkg;

    // Width of PC, addresses and instruction words.
    localparam int unsigned WORD_BITWIDTH = 32;

    // Low address bits that must be zero for a word-aligned instruction.
    localparam int unsigned ALIGN_BITS = 2;

    // Byte distance between consecutive instructions.
    localparam int unsigned INST_BYTES = 4;

    // PC loaded on reset unless the instance overrides it.
    localparam logic [WORD_BITWIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        DRAIN = 2'd3
    } fetchState_e;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_pc_next.sv
// Next-address select: sequential pc+4 or the word-aligned redirect target.
module pc_next
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WORD_BITWIDTH = fetch_unit_pkg::WORD_BITWIDTH
) (
    input  logic [WORD_BITWIDTH-1:0] basePc,
    input  logic                     redirect,
    input  logic [WORD_BITWIDTH-1:0] redirectTarget,
    output logic [WORD_BITWIDTH-1:0] seqPc_c,
    output logic [WORD_BITWIDTH-1:0] alignedTarget_c,
    output logic [WORD_BITWIDTH-1:0] nextPc_c
);

    // Sequential address wraps naturally modulo 2^WORD_BITWIDTH; target low bits are forced to zero.
    always_comb begin
        seqPc_c         = basePc + WORD_BITWIDTH'(INST_BYTES);
        alignedTarget_c = {redirectTarget[WORD_BITWIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
        nextPc_c        = redirect ? alignedTarget_c : seqPc_c;
    end

endmodule : pc_next

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory, hands one
// instruction at a time to decode, and follows redirects from execute.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned               WORD_BITWIDTH = fetch_unit_pkg::WORD_BITWIDTH,
    parameter logic [WORD_BITWIDTH-1:0]  RESET_PC      = WORD_BITWIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [WORD_BITWIDTH-1:0] imem_addr,
    input  logic                     imem_ready,
    input  logic [WORD_BITWIDTH-1:0] imem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [WORD_BITWIDTH-1:0] instruction,
    output logic [WORD_BITWIDTH-1:0] pc,
    input  logic                     redirect,
    input  logic [WORD_BITWIDTH-1:0] redirect_target
);

    fetchState_e state;
    fetchState_e nextState;

    logic [WORD_BITWIDTH-1:0] fetchPc;
    logic [WORD_BITWIDTH-1:0] reqAddr;
    logic [WORD_BITWIDTH-1:0] pcReg;
    logic [WORD_BITWIDTH-1:0] instReg;
    logic                     reqReg;
    logic                     validReg;
    logic                     reqNext;
    logic                     validNext;

    logic [WORD_BITWIDTH-1:0] seqPc;
    logic [WORD_BITWIDTH-1:0] alignedTarget;
    logic [WORD_BITWIDTH-1:0] nextPc;

    pc_next #(
        .WORD_BITWIDTH (WORD_BITWIDTH)
    ) u_pcNext (
        .basePc          (pcReg),
        .redirect        (redirect),
        .redirectTarget  (redirect_target),
        .seqPc_c         (seqPc),
        .alignedTarget_c (alignedTarget),
        .nextPc_c        (nextPc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state selection; a redirect always wins over a decode handshake.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    nextState = FETCH;
            FETCH: begin
                if (redirect) begin
                    nextState = imem_ready ? FETCH : DRAIN;
                end else if (imem_ready) begin
                    nextState = VALID;
                end
            end
            VALID: begin
                if (redirect || inst_ready) begin
                    nextState = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    nextState = FETCH;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the handshake outputs can be registered.
    always_comb begin
        reqNext   = 1'b0;
        validNext = 1'b0;
        unique case (nextState)
            FETCH, DRAIN: reqNext   = 1'b1;
            VALID:        validNext = 1'b1;
            default: begin
                reqNext   = 1'b0;
                validNext = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            reqReg   <= 1'b0;
            validReg <= 1'b0;
        end else begin
            reqReg   <= reqNext;
            validReg <= validNext;
        end
    end

    // Address and instruction datapath; request address only moves when no request is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc <= RESET_PC;
            reqAddr <= RESET_PC;
            pcReg   <= RESET_PC;
            instReg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) begin
                        fetchPc <= alignedTarget;
                        reqAddr <= alignedTarget;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        fetchPc <= alignedTarget;
                        if (imem_ready) begin
                            reqAddr <= alignedTarget;
                        end
                    end else if (imem_ready) begin
                        instReg <= imem_rdata;
                        pcReg   <= reqAddr;
                    end
                end
                VALID: begin
                    if (redirect || inst_ready) begin
                        fetchPc <= nextPc;
                        reqAddr <= nextPc;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        fetchPc <= alignedTarget;
                    end
                    if (imem_ready) begin
                        reqAddr <= redirect ? alignedTarget : fetchPc;
                    end
                end
                default: begin
                    fetchPc <= fetchPc;
                end
            endcase
        end
    end

    assign imem_req    = reqReg;
    assign imem_addr   = reqAddr;
    assign inst_valid  = validReg;
    assign instruction = instReg;
    assign pc          = pcReg;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a
// transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_target;

    // Second instance with a PC near the top of the address space.
    logic        rstB;
    logic        imemReqB;
    logic [31:0] imemAddrB;
    logic [31:0] imemRdataB;
    logic        instValidB;
    logic [31:0] instructionB;
    logic [31:0] pcB;

    int errors = 0;
    int checks = 0;

    // Reference model: request/holding flags rather than a state code.
    bit          mReq;
    bit          mValid;
    bit          mDrop;
    logic [31:0] mAddr;
    logic [31:0] mInst;
    logic [31:0] mPc;
    logic [31:0] mFetchPc;

    localparam logic [31:0] RESET_A = 32'h0000_0000;
    localparam logic [31:0] RESET_B = 32'hFFFF_FFFC;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign imem_rdata = memWord(imem_addr);
    assign imemRdataB = memWord(imemAddrB);

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .instruction     (instruction),
        .pc              (pc),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    fetch_unit #(
        .RESET_PC (RESET_B)
    ) dutB (
        .clk             (clk),
        .rst             (rstB),
        .imem_req        (imemReqB),
        .imem_addr       (imemAddrB),
        .imem_ready      (1'b1),
        .imem_rdata      (imemRdataB),
        .inst_valid      (instValidB),
        .inst_ready      (1'b1),
        .instruction     (instructionB),
        .pc              (pcB),
        .redirect        (1'b0),
        .redirect_target (32'h0)
    );

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference model, using the inputs seen at the edge.
    task automatic modelUpdate(input bit r, input bit rdy, input bit irdy,
                               input bit rd, input logic [31:0] tgt);
        logic [31:0] t;
        t = tgt & 32'hFFFF_FFFC;
        if (r) begin
            mReq = 0; mValid = 0; mDrop = 0;
            mAddr = RESET_A; mInst = '0; mPc = RESET_A; mFetchPc = RESET_A;
        end else if (!mReq && !mValid) begin
            mReq = 1;
            if (rd) begin
                mAddr = t;
                mFetchPc = t;
            end
        end else if (mValid) begin
            if (rd || irdy) begin
                mValid = 0;
                mReq = 1;
                mAddr = rd ? t : mPc + 32'd4;
                mFetchPc = mAddr;
            end
        end else begin
            if (rd) mFetchPc = t;
            if (rdy) begin
                if (mDrop || rd) begin
                    mAddr = mFetchPc;
                    mDrop = 0;
                end else begin
                    mInst = memWord(mAddr);
                    mPc = mAddr;
                    mReq = 0;
                    mValid = 1;
                end
            end else if (rd) begin
                mDrop = 1;
            end
        end
    endtask

    task automatic compareAll();
        checkValue("imem_req", {31'b0, imem_req}, {31'b0, mReq});
        checkValue("imem_addr", imem_addr, mAddr);
        checkValue("inst_valid", {31'b0, inst_valid}, {31'b0, mValid});
        checkValue("pc", pc, mPc);
        checkValue("instruction", instruction, mInst);
    endtask

    task automatic step(input bit r, input bit rdy, input bit irdy,
                        input bit rd, input logic [31:0] tgt);
        rst = r; imem_ready = rdy; inst_ready = irdy;
        redirect = rd; redirect_target = tgt;
        @(posedge clk);
        modelUpdate(r, rdy, irdy, rd, tgt);
        #1;
        compareAll();
    endtask

    // Advance with decode stalled until an instruction is held, within a bound.
    task automatic reachValid();
        int n;
        n = 0;
        while (!inst_valid && n < 10) begin
            step(0, 1, 0, 0, 32'h0);
            n++;
        end
        checkValue("reach_valid", {31'b0, inst_valid}, 32'd1);
    endtask

    initial begin
        rstB = 1'b1;

        // Reset, including a stray redirect and ready.
        step(1, 0, 0, 0, 32'h0);
        step(1, 1, 1, 1, 32'h40);
        checkValue("rst_req", {31'b0, imem_req}, 32'd0);
        checkValue("rst_addr", imem_addr, RESET_A);

        // Zero-wait memory and always-ready decode.
        step(0, 1, 1, 0, 32'h0);
        checkValue("first_req", {31'b0, imem_req}, 32'd1);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 32'h0);

        // Memory wait of 3 cycles then decode stall of 2 cycles.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 32'h0);

        // Redirect beats decode accept in VALID.
        reachValid();
        step(0, 1, 1, 1, 32'h0000_0103);
        checkValue("redir_valid_drop", {31'b0, inst_valid}, 32'd0);
        checkValue("redir_valid_addr", imem_addr, 32'h0000_0100);
        step(0, 1, 0, 0, 32'h0);
        checkValue("redir_valid_pc", pc, 32'h0000_0100);

        // Redirect while waiting on memory, second redirect during the drain.
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 1, 32'h0000_0200);
        step(0, 0, 1, 1, 32'h0000_0300);
        checkValue("drain_no_valid", {31'b0, inst_valid}, 32'd0);
        step(0, 1, 1, 0, 32'h0);
        checkValue("drain_addr", imem_addr, 32'h0000_0300);
        step(0, 1, 0, 0, 32'h0);
        checkValue("drain_pc", pc, 32'h0000_0300);
        checkValue("drain_valid", {31'b0, inst_valid}, 32'd1);

        // Reset in FETCH together with a redirect.
        step(0, 0, 1, 0, 32'h0);
        step(1, 1, 1, 1, 32'h0000_0555);
        checkValue("midrst_req", {31'b0, imem_req}, 32'd0);
        checkValue("midrst_valid", {31'b0, inst_valid}, 32'd0);
        checkValue("midrst_pc", pc, RESET_A);
        checkValue("midrst_inst", instruction, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        checkValue("restart_addr", imem_addr, RESET_A);
        step(0, 1, 1, 0, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 11) == 0,
                 $urandom);
        end

        // PC wrap at the top of the address space on the second instance.
        rstB = 1'b0;
        step(0, 1, 1, 0, 32'h0);
        checkValue("wrap_req0", {31'b0, imemReqB}, 32'd1);
        checkValue("wrap_addr0", imemAddrB, RESET_B);
        step(0, 1, 1, 0, 32'h0);
        checkValue("wrap_valid", {31'b0, instValidB}, 32'd1);
        checkValue("wrap_pc", pcB, RESET_B);
        checkValue("wrap_inst", instructionB, memWord(RESET_B));
        step(0, 1, 1, 0, 32'h0);
        checkValue("wrap_req1", {31'b0, imemReqB}, 32'd1);
        checkValue("wrap_addr1", imemAddrB, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_unit
